updown_counter_mod: RTL
=======================

// Module: updown_counter_mod
// PURPOSE
//  Parametrised up/down counter with programmable modulus, step size, load/clear and
//  selectable boundary mode (wrap, saturate, halt). Next generation of the team's
//  up/down counter: adds modulo wrap, multi-step counting, underflow vs overflow flags
//  and a terminal-count pulse. Used as event/credit/index counter in datapath control.
// PARAMETERS
//  COUNTER_WIDTH  5            width of count
//  MAX_VAL        2**W-1       terminal value; count range 0..MAX_VAL (legal: 1..2**W-1)
//  STEP_WIDTH     2            width of step; 2**STEP_WIDTH-1 must be <= MAX_VAL
//  MODE           0            0=WRAP (modulo MAX_VAL+1), 1=SAT (clamp), 2=HALT (clamp+freeze)
// PORTS
//  clk        in   1               clock, all logic rising-edge
//  rst        in   1               asynchronous reset, active-high
//  en         in   1               count enable, sampled each clk
//  up_down_n  in   1               1=count up, 0=count down
//  step       in   STEP_WIDTH      increment/decrement amount; 0 = hold
//  load       in   1               synchronous load of load_val
//  load_val   in   COUNTER_WIDTH   load value; values > MAX_VAL clamp to MAX_VAL
//  clr        in   1               synchronous clear
//  count      out  COUNTER_WIDTH   current count (registered)
//  ovflw      out  1               sticky: an up-step exceeded MAX_VAL
//  unflw      out  1               sticky: a down-step went below 0
//  tc         out  1               one-cycle pulse: the previous update over/underflowed
//  halted     out  1               high while FSM in HALT
// BEHAVIOUR
//  - One clock, async active-high rst: count=0, ovflw=0, unflw=0, tc=0, halted=0, state=IDLE.
//  - FSM one-hot: IDLE=4'b0001, CNTUP=4'b0010, CNTDN=4'b0100, HALT=4'b1000.
//    IDLE/CNTUP/CNTDN: en=0 -> IDLE; en=1 -> CNTUP if up_down_n else CNTDN.
//    MODE=2 and over/underflow event -> HALT. HALT left only by clr (-> IDLE) or rst.
//  - Latency: inputs sampled at edge N; count/flags/tc reflect them after edge N.
//  - Priority per edge: clr > load > count step. clr: count=0, ovflw=unflw=0, state=IDLE.
//    load: count=min(load_val,MAX_VAL); flags unchanged; state from en/up_down_n rule.
//  - In HALT: en, load ignored; count frozen; tc=0.
//  - Arithmetic in COUNTER_WIDTH+1 bits, no truncation before boundary compare.
//    Up:   s=count+step; s>MAX_VAL -> overflow event;
//          WRAP count=s-(MAX_VAL+1); SAT/HALT count=MAX_VAL.
//    Down: step>count -> underflow event;
//          WRAP count=count+(MAX_VAL+1)-step; SAT/HALT count=0.
//    Landing exactly on MAX_VAL or 0 is NOT an event.
//  - Event: sets matching sticky flag; tc=1 for exactly the next cycle (repeated events -> tc
//    stays high each cycle). step=0 with en=1: count held, state follows direction, no event.
//  - count never exceeds MAX_VAL in any mode, including after load.
//  - Reset mid-operation: outputs return to reset values asynchronously, no pending tc survives.
//  - Illegal state encoding: synthesisable recovery to IDLE; simulation $display warning.
// STRUCTURE
//  - Package updown_counter_pkg: MODE_WRAP/MODE_SAT/MODE_HALT constants, one-hot state
//    localparams, state width.
//  - Sub-module updown_step_calc (combinational): count, step, up_down_n, MAX_VAL, MODE ->
//    next_count, ovf_evt, unf_evt. Top holds FSM, count/flag/tc registers.
// TESTING (COUNTER_WIDTH=4, MAX_VAL=9, STEP_WIDTH=2 unless noted)
//  - WRAP: load 8, then en=1 up step=3 -> count=1, ovflw=1, tc=1 for one cycle, unflw=0.
//  - SAT: load 1, en=1 down step=3 -> count=0, unflw=1, tc pulse; repeat -> count stays 0,
//    tc high again.
//  - HALT: load 9, en=1 up step=1 -> count=9, halted=1, ovflw=1; 3 more en cycles and
//    load 4 -> count 9; clr -> count=0, halted=0, flags=0.
//  - Priority/clamp: clr=1 and load=1 (load_val=5) same edge -> count=0; load_val=15 -> count=9.
//  - Exact boundary: WRAP count=6 up step=3 -> 9, no flag/tc; step=0 en=1 -> count held.
//  - Async rst asserted mid-count (count=7, ovflw=1) between edges -> count=0, flags=0
//    immediately; counting resumes one edge after rst deasserts.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter family: boundary modes and FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package updown_counter_pkg;

  // Boundary behaviour selected by the MODE parameter
  localparam int MODE_WRAP = 0;  // modulo MAX_VAL+1
  localparam int MODE_SAT  = 1;  // clamp at 0 / MAX_VAL, keep counting
  localparam int MODE_HALT = 2;  // clamp, then freeze until clr

  // One-hot FSM encoding
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] S_IDLE_ENC  = 4'b0001;
  localparam logic [STATE_W-1:0] S_CNTUP_ENC = 4'b0010;
  localparam logic [STATE_W-1:0] S_CNTDN_ENC = 4'b0100;
  localparam logic [STATE_W-1:0] S_HALT_ENC  = 4'b1000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE_ENC,
    ST_CNTUP = S_CNTUP_ENC,
    ST_CNTDN = S_CNTDN_ENC,
    ST_HALT  = S_HALT_ENC
  } state_e;

endpackage

// File: rtl/updown_step_calc.sv
// Next-count calculator: applies one up/down step with wrap or clamp at the boundaries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
module updown_step_calc
  import updown_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 5,
  parameter int STEP_WIDTH    = 2,
  parameter int MAX_VAL       = (1 << COUNTER_WIDTH) - 1,
  parameter int MODE          = MODE_WRAP
) (
  input  logic [COUNTER_WIDTH-1:0] count,
  input  logic [STEP_WIDTH-1:0]    step,
  input  logic                     up_down_n,
  output logic [COUNTER_WIDTH-1:0] next_count,
  output logic                     ovf_evt,
  output logic                     unf_evt
);

  // One extra bit so the sum/difference never truncates before the boundary compare
  localparam int EW = COUNTER_WIDTH + 1;
  localparam logic [EW-1:0] MAX_EXT = EW'(MAX_VAL);
  localparam logic [EW-1:0] MOD_EXT = EW'(MAX_VAL + 1);

  logic [EW-1:0] cnt_ext;
  logic [EW-1:0] step_ext;
  logic [EW-1:0] sum_ext;
  logic [EW-1:0] wrap_dn_ext;

  // Extended-width arithmetic for both directions
  always_comb begin
    cnt_ext     = {1'b0, count};
    step_ext    = EW'(step);
    sum_ext     = cnt_ext + step_ext;
    wrap_dn_ext = cnt_ext + MOD_EXT - step_ext;
  end

  // Boundary decision: landing exactly on 0 or MAX_VAL is a normal step, not an event
  always_comb begin
    next_count = count;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (up_down_n) begin
      if (sum_ext > MAX_EXT) begin
        ovf_evt    = 1'b1;
        next_count = (MODE == MODE_WRAP) ? COUNTER_WIDTH'(sum_ext - MOD_EXT)
                                         : COUNTER_WIDTH'(MAX_VAL);
      end else begin
        next_count = sum_ext[COUNTER_WIDTH-1:0];
      end
    end else begin
      if (step_ext > cnt_ext) begin
        unf_evt    = 1'b1;
        next_count = (MODE == MODE_WRAP) ? COUNTER_WIDTH'(wrap_dn_ext)
                                         : '0;
      end else begin
        next_count = COUNTER_WIDTH'(cnt_ext - step_ext);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, multi-step, load/clear and wrap/sat/halt boundary modes.
// Latency: inputs sampled at a rising edge show on count/flags/tc right after that edge.
// Backpressure: none; every cycle is accepted, HALT mode ignores en/load until clr.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 5,
  parameter int MAX_VAL       = (1 << COUNTER_WIDTH) - 1,
  parameter int STEP_WIDTH    = 2,
  parameter int MODE          = MODE_WRAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     up_down_n,
  input  logic [STEP_WIDTH-1:0]    step,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_val,
  input  logic                     clr,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     ovflw,
  output logic                     unflw,
  output logic                     tc,
  output logic                     halted
);

  localparam logic [COUNTER_WIDTH:0] MAX_EXT = (COUNTER_WIDTH + 1)'(MAX_VAL);
  localparam logic [COUNTER_WIDTH-1:0] MAX_CNT = COUNTER_WIDTH'(MAX_VAL);

  state_e                     state;
  state_e                     dir_state;
  logic [COUNTER_WIDTH-1:0]   next_count;
  logic [COUNTER_WIDTH-1:0]   load_clamped;
  logic                       ovf_evt;
  logic                       unf_evt;
  logic                       bnd_evt;

  updown_step_calc #(
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .STEP_WIDTH    (STEP_WIDTH),
    .MAX_VAL       (MAX_VAL),
    .MODE          (MODE)
  ) u_step_calc (
    .count      (count),
    .step       (step),
    .up_down_n  (up_down_n),
    .next_count (next_count),
    .ovf_evt    (ovf_evt),
    .unf_evt    (unf_evt)
  );

  // Direction-driven next state and clamped load value; compare in the wide domain
  // so a MAX_VAL at the top of the range does not turn into a constant compare
  always_comb begin
    dir_state = ST_IDLE;
    if (en) begin
      dir_state = up_down_n ? ST_CNTUP : ST_CNTDN;
    end
    load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_CNT : load_val;
    bnd_evt      = ovf_evt | unf_evt;
  end

  // FSM plus count, sticky flags and terminal-count pulse; priority clr > load > step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      ovflw  <= 1'b0;
      unflw  <= 1'b0;
      tc     <= 1'b0;
      halted <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        state  <= ST_IDLE;
        count  <= '0;
        ovflw  <= 1'b0;
        unflw  <= 1'b0;
        halted <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_CNTUP, ST_CNTDN: begin
            if (load) begin
              count <= load_clamped;
              state <= dir_state;
            end else if (en) begin
              count <= next_count;
              ovflw <= ovflw | ovf_evt;
              unflw <= unflw | unf_evt;
              tc    <= bnd_evt;
              if ((MODE == MODE_HALT) && bnd_evt) begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end else begin
                state <= dir_state;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HALT: begin
            // Frozen: count, flags and halted hold until clr or rst
            halted <= 1'b1;
          end
          default: begin
            // Corrupted encoding: fall back to a known-good idle state
            state  <= ST_IDLE;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

  // Flag a corrupted one-hot state in simulation; ignored by synthesis
  illegal_state_chk: assert property (@(posedge clk) disable iff (rst) $onehot(state))
    else $warning("updown_counter_mod: illegal state encoding %b, recovering to IDLE", state);

endmodule
